// File: rtl/memory_access.sv
// memory_access: MIPS memory stage. Issues one data-bus access at a time,
// aligns/extends load data and raises address-error exceptions.
module memory_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rm,
  input  logic        wm,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        adel,
  output logic        ades
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2a;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SWR = 6'h2e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wm_q, wm_d;
  logic        drop_q, drop_d;

  logic        access;
  logic        misalign;
  logic [1:0]  a;
  logic [1:0]  bus_size;
  logic [3:0]  bus_strobe;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic [31:0] ld_data;
  logic [31:0] m_byte;
  logic [31:0] m_half;

  assign access = in_valid & (rm | wm) & ~flush;
  assign a      = addr_q[1:0];

  always_comb begin
    unique case (op)
      OP_LW, OP_SW:         misalign = |addr[1:0];
      OP_LH, OP_LHU, OP_SH: misalign = addr[0];
      default:              misalign = 1'b0;
    endcase
  end

  always_comb begin
    bus_size   = 2'd2;
    bus_strobe = 4'b0000;
    bus_data   = 32'h0;
    bus_addr   = addr_q;
    unique case (op_q)
      OP_LB, OP_LBU: bus_size = 2'd0;
      OP_LH, OP_LHU: bus_size = 2'd1;
      OP_LWL, OP_LWR: bus_addr = {addr_q[31:2], 2'b00};
      OP_SB: begin
        bus_size   = 2'd0;
        bus_strobe = 4'b0001 << a;
        bus_data   = {4{wdata_q[7:0]}};
      end
      OP_SH: begin
        bus_size   = 2'd1;
        bus_strobe = 4'b0011 << a;
        bus_data   = {2{wdata_q[15:0]}};
      end
      OP_SWL: begin
        bus_addr   = {addr_q[31:2], 2'b00};
        bus_strobe = 4'b1111 >> (2'd3 - a);
        bus_data   = wdata_q >> {(2'd3 - a), 3'b000};
      end
      OP_SWR: begin
        bus_addr   = {addr_q[31:2], 2'b00};
        bus_strobe = 4'b1111 << a;
        bus_data   = wdata_q << {a, 3'b000};
      end
      default: begin
        if (wm_q) begin
          bus_strobe = 4'b1111;
          bus_data   = wdata_q;
        end
      end
    endcase
  end

  // wdata_q doubles as the old rt value merged by LWL/LWR
  always_comb begin
    m_byte  = rdata_q >> {a, 3'b000};
    m_half  = rdata_q >> {a[1], 4'b0000};
    ld_data = wm_q ? 32'h0 : rdata_q;
    unique case (op_q)
      OP_LB:  ld_data = {{24{m_byte[7]}}, m_byte[7:0]};
      OP_LBU: ld_data = {24'h0, m_byte[7:0]};
      OP_LH:  ld_data = {{16{m_half[15]}}, m_half[15:0]};
      OP_LHU: ld_data = {16'h0, m_half[15:0]};
      OP_LWL: begin
        unique case (a)
          2'd0:    ld_data = {rdata_q[7:0], wdata_q[23:0]};
          2'd1:    ld_data = {rdata_q[15:0], wdata_q[15:0]};
          2'd2:    ld_data = {rdata_q[23:0], wdata_q[7:0]};
          default: ld_data = rdata_q;
        endcase
      end
      OP_LWR: begin
        unique case (a)
          2'd0:    ld_data = rdata_q;
          2'd1:    ld_data = {wdata_q[31:24], rdata_q[31:8]};
          2'd2:    ld_data = {wdata_q[31:16], rdata_q[31:16]};
          default: ld_data = {wdata_q[31:8], rdata_q[31:24]};
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    wm_d        = wm_q;
    drop_d      = drop_q;
    dreq_valid  = 1'b0;
    dreq_addr   = 32'h0;
    dreq_size   = 2'd0;
    dreq_strobe = 4'b0000;
    dreq_data   = 32'h0;
    stall       = 1'b0;
    out_valid   = 1'b0;
    out_data    = 32'h0;
    adel        = 1'b0;
    ades        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (access && misalign) begin
          out_valid = 1'b1;
          adel      = rm;
          ades      = wm;
        end else if (access) begin
          stall   = 1'b1;
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          wm_d    = wm;
          drop_d  = 1'b0;
          state_d = S_REQ;
        end else if (in_valid && !flush) begin
          out_valid = 1'b1;
          out_data  = addr;
        end
      end
      S_REQ: begin
        dreq_valid  = 1'b1;
        dreq_addr   = bus_addr;
        dreq_size   = bus_size;
        dreq_strobe = bus_strobe;
        dreq_data   = bus_data;
        stall       = 1'b1;
        drop_d      = drop_q | flush;
        if (dresp_addr_ok && dresp_data_ok) begin
          rdata_d = dresp_data;
          state_d = S_DONE;
        end else if (dresp_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall  = 1'b1;
        drop_d = drop_q | flush;
        if (dresp_data_ok) begin
          rdata_d = dresp_data;
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid = ~drop_q;
        out_data  = drop_q ? 32'h0 : ld_data;
        state_d   = S_IDLE;
      end
    endcase
    // Keep every output quiet while reset is held, even with live inputs
    if (!resetn) begin
      dreq_valid  = 1'b0;
      dreq_addr   = 32'h0;
      dreq_size   = 2'd0;
      dreq_strobe = 4'b0000;
      dreq_data   = 32'h0;
      stall       = 1'b0;
      out_valid   = 1'b0;
      out_data    = 32'h0;
      adel        = 1'b0;
      ades        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= 6'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      wm_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wm_q    <= wm_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: random and directed accesses against a byte-level
// reference model of the memory stage.
module tb_memory_access;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2a;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SWR = 6'h2e;
  localparam logic [5:0] OP_ADD = 6'h00;

  logic        clk, resetn, in_valid, rm, wm, flush;
  logic [5:0]  op;
  logic [31:0] addr, wdata, dresp_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic        dreq_valid, stall, out_valid, adel, ades;
  logic [31:0] dreq_addr, dreq_data, out_data;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;

  int checks = 0;
  int errors = 0;

  memory_access dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .op(op),
    .addr(addr), .wdata(wdata), .rm(rm), .wm(wm), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .stall(stall), .out_valid(out_valid), .out_data(out_data),
    .adel(adel), .ades(ades)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_load(input logic [5:0] o);
    return o inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
  endfunction

  function automatic bit is_store(input logic [5:0] o);
    return o inside {OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR};
  endfunction

  function automatic bit ref_mis(input logic [5:0] o, input logic [1:0] a);
    if (o == OP_LW || o == OP_SW) return a != 2'd0;
    if (o == OP_LH || o == OP_LHU || o == OP_SH) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [1:0] ref_size(input logic [5:0] o);
    if (o inside {OP_LB, OP_LBU, OP_SB}) return 2'd0;
    if (o inside {OP_LH, OP_LHU, OP_SH}) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] ref_addr(input logic [5:0] o,
                                           input logic [31:0] a);
    if (o inside {OP_LWL, OP_LWR, OP_SWL, OP_SWR}) return a & ~32'h3;
    return a;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] o,
      input int ai, input logic [31:0] m, input logic [31:0] rt);
    logic [7:0] mb[4];
    logic [7:0] rs[4];
    logic [15:0] h;
    for (int k = 0; k < 4; k++) begin
      mb[k] = m[8*k +: 8];
      rs[k] = rt[8*k +: 8];
    end
    h = {mb[(ai & 2) + 1], mb[ai & 2]};
    case (o)
      OP_LB:  return {{24{mb[ai][7]}}, mb[ai]};
      OP_LBU: return {24'h0, mb[ai]};
      OP_LH:  return {{16{h[15]}}, h};
      OP_LHU: return {16'h0, h};
      OP_LW:  return m;
      OP_LWL: begin
        for (int k = 0; k < 4; k++)
          if (k >= 3 - ai) rs[k] = mb[k - (3 - ai)];
        return {rs[3], rs[2], rs[1], rs[0]};
      end
      OP_LWR: begin
        for (int k = 0; k < 4; k++)
          if (k <= 3 - ai) rs[k] = mb[k + ai];
        return {rs[3], rs[2], rs[1], rs[0]};
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic ref_store(input logic [5:0] o, input int ai,
      input logic [31:0] rt, output logic [3:0] st, output logic [31:0] d);
    logic [7:0] rb[4];
    logic [7:0] db[4];
    for (int k = 0; k < 4; k++) begin
      rb[k] = rt[8*k +: 8];
      db[k] = 8'h0;
    end
    st = 4'b0000;
    case (o)
      OP_SB: begin
        st[ai] = 1'b1;
        for (int k = 0; k < 4; k++) db[k] = rb[0];
      end
      OP_SH: begin
        st[ai] = 1'b1;
        st[ai + 1] = 1'b1;
        for (int k = 0; k < 4; k++) db[k] = rb[k % 2];
      end
      OP_SW: begin
        st = 4'b1111;
        for (int k = 0; k < 4; k++) db[k] = rb[k];
      end
      OP_SWL:
        for (int j = 0; j <= ai; j++) begin
          st[j] = 1'b1;
          db[j] = rb[j + 3 - ai];
        end
      OP_SWR:
        for (int j = ai; j < 4; j++) begin
          st[j] = 1'b1;
          db[j] = rb[j - ai];
        end
      default: ;
    endcase
    d = {db[3], db[2], db[1], db[0]};
  endtask

  task automatic check_req(input logic [5:0] o, input logic [31:0] a,
      input logic [3:0] es, input logic [31:0] ed);
    chk("req_valid", dreq_valid, 1);
    chk("req_addr", dreq_addr, ref_addr(o, a));
    chk("req_size", dreq_size, ref_size(o));
    chk("req_strobe", dreq_strobe, es);
    chk("req_data", dreq_data, ed);
    chk("req_stall", stall, 1);
    chk("req_outv", out_valid, 0);
  endtask

  task automatic access(input logic [5:0] o, input logic [31:0] a,
      input logic [31:0] wd, input int adly, input int ddly,
      input logic [31:0] rd, input bit fl, output logic [31:0] obs,
      output logic [3:0] obs_st, output logic [31:0] obs_bd);
    logic [3:0]  es;
    logic [31:0] ed;
    bit ld, sq;
    ld = is_load(o);
    sq = is_store(o);
    ref_store(o, int'(a[1:0]), wd, es, ed);
    obs = 32'h0;
    obs_st = 4'h0;
    obs_bd = 32'h0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; addr = a; wdata = wd; rm = ld; wm = sq;
    @(negedge clk);
    if (!(ld || sq)) begin
      chk("pt_valid", out_valid, 1);
      chk("pt_data", out_data, a);
      chk("pt_stall", stall, 0);
      obs = out_data;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else if (ref_mis(o, a[1:0])) begin
      chk("mis_valid", out_valid, 1);
      chk("mis_adel", adel, ld);
      chk("mis_ades", ades, sq);
      chk("mis_data", out_data, 0);
      chk("mis_stall", stall, 0);
      chk("mis_req", dreq_valid, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("mis_noreq", dreq_valid, 0);
    end else begin
      chk("idle_stall", stall, 1);
      chk("idle_req", dreq_valid, 0);
      chk("idle_outv", out_valid, 0);
      @(posedge clk); #1;
      in_valid = 1'b0; op = 6'($urandom); addr = $urandom; wdata = $urandom;
      for (int i = 0; i < adly; i++) begin
        @(negedge clk);
        check_req(o, a, es, ed);
        @(posedge clk); #1;
      end
      dresp_addr_ok = 1'b1;
      if (ddly == 0) begin
        dresp_data_ok = 1'b1;
        dresp_data = rd;
      end
      @(negedge clk);
      check_req(o, a, es, ed);
      obs_st = dreq_strobe;
      obs_bd = dreq_data;
      @(posedge clk); #1;
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      dresp_data = $urandom;
      if (ddly > 0) begin
        flush = fl;
        for (int i = 1; i < ddly; i++) begin
          @(negedge clk);
          chk("wait_stall", stall, 1);
          chk("wait_req", dreq_valid, 0);
          chk("wait_outv", out_valid, 0);
          @(posedge clk); #1;
          flush = 1'b0;
        end
        dresp_data_ok = 1'b1;
        dresp_data = rd;
        @(negedge clk);
        chk("wait_stall", stall, 1);
        @(posedge clk); #1;
        dresp_data_ok = 1'b0;
        flush = 1'b0;
        dresp_data = $urandom;
      end
      @(negedge clk);
      chk("done_valid", out_valid, !fl);
      if (!fl) chk("done_data", out_data, ld ? ref_load(o, int'(a[1:0]), rd, wd) : 0);
      chk("done_stall", stall, 0);
      chk("done_req", dreq_valid, 0);
      chk("done_exc", {adel, ades}, 0);
      obs = out_data;
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_outv", out_valid, 0);
      chk("post_stall", stall, 0);
    end
  endtask

  logic [5:0] ops[13] = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU,
                          OP_LWR, OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR, OP_ADD};

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] obs, bd;
    logic [3:0]  st;
    logic [5:0]  o;
    int dd;
    resetn = 1'b0; in_valid = 1'b0; op = 6'h0; addr = 32'h0; wdata = 32'h0;
    rm = 1'b0; wm = 1'b0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req", dreq_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_outv", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", dreq_addr, 0);
    chk("rst_exc", {adel, ades}, 0);
    resetn = 1'b1;

    access(OP_LW, 32'h1000, 32'h0, 0, 0, 32'hDEADBEEF, 0, obs, st, bd);
    chk("dir_lw", obs, 32'hDEADBEEF);
    access(OP_LB, 32'h1003, 32'h0, 0, 4, 32'h80FFFFFF, 0, obs, st, bd);
    chk("dir_lb", obs, 32'hFFFFFF80);
    access(OP_LBU, 32'h1003, 32'h0, 0, 4, 32'h80FFFFFF, 0, obs, st, bd);
    chk("dir_lbu", obs, 32'h00000080);
    access(OP_SH, 32'h2002, 32'h1234ABCD, 3, 1, 32'h0, 0, obs, st, bd);
    chk("dir_sh_strb", st, 4'b1100);
    chk("dir_sh_data", bd, 32'hABCDABCD);
    chk("dir_sh_out", obs, 0);
    access(OP_LWL, 32'h3001, 32'h11223344, 1, 0, 32'hAABBCCDD, 0, obs, st, bd);
    chk("dir_lwl", obs, 32'hCCDD3344);
    access(OP_LWR, 32'h3001, 32'h11223344, 0, 2, 32'hAABBCCDD, 0, obs, st, bd);
    chk("dir_lwr", obs, 32'h11AABBCC);
    access(OP_LW, 32'h1002, 32'h0, 0, 0, 32'h0, 0, obs, st, bd);
    access(OP_SW, 32'h1001, 32'h5, 0, 0, 32'h0, 0, obs, st, bd);
    access(OP_LW, 32'h4000, 32'h0, 1, 2, 32'h12345678, 1, obs, st, bd);
    access(OP_ADD, 32'hCAFEF00D, 32'h0, 0, 0, 32'h0, 0, obs, st, bd);

    // stray data_ok while idle must not produce a result
    @(posedge clk); #1;
    dresp_data_ok = 1'b1;
    @(negedge clk);
    chk("idle_dok_outv", out_valid, 0);
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("idle_dok_outv2", out_valid, 0);

    // reset pulse in the middle of a request
    @(posedge clk); #1;
    in_valid = 1'b1; op = OP_LW; addr = 32'h5000; rm = 1'b1; wm = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; rm = 1'b0;
    @(negedge clk);
    chk("rp_req", dreq_valid, 1);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("rp_req_drop", dreq_valid, 0);
    chk("rp_stall_drop", stall, 0);
    @(negedge clk);
    resetn = 1'b1;
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    @(negedge clk);
    chk("rp_idle_req", dreq_valid, 0);
    chk("rp_idle_outv", out_valid, 0);
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    access(OP_LHU, 32'h6002, 32'h0, 0, 1, 32'hBEEF1234, 0, obs, st, bd);
    chk("rp_after", obs, 32'h0000BEEF);

    for (int n = 0; n < 400; n++) begin
      o = ops[$urandom_range(0, 12)];
      dd = $urandom_range(0, 3);
      access(o, $urandom, $urandom, $urandom_range(0, 3), dd, $urandom,
             (dd > 0) && ($urandom_range(0, 7) == 0), obs, st, bd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
